// File: rtl/adder_multicycle.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry held in a
// register between slices. Results post on a single-cycle outDone pulse.
module adder_multicycle #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inStart,
  input  logic             inSub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inCarry,
  output logic             outBusy,
  output logic             outDone,
  output logic [WIDTH-1:0] outSum,
  output logic             outCarry,
  output logic             outOverflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opA, r_opB, r_work;
  logic             r_carry;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0] w_merged;
  logic [CHUNK:0]   w_step;
  logic             w_last, w_accept;

  always_comb begin
    w_step   = {1'b0, r_opA[r_idx*CHUNK +: CHUNK]}
             + {1'b0, r_opB[r_idx*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, r_carry};
    // Final slice is merged combinationally so the result posts on the last step edge.
    w_merged = r_work;
    w_merged[r_idx*CHUNK +: CHUNK] = w_step[CHUNK-1:0];
    w_accept = (r_state == S_IDLE) && inStart;
    w_last   = (r_state == S_RUN) && (r_idx == IW'(N-1));
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (inStart) w_state_nxt = S_RUN;
      S_RUN:  if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA       <= '0;
      r_opB       <= '0;
      r_work      <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      outDone     <= 1'b0;
      outSum      <= '0;
      outCarry    <= 1'b0;
      outOverflow <= 1'b0;
    end else begin
      outDone <= 1'b0;
      if (w_accept) begin
        // Subtract is A + ~B + ~borrow_in; the carry-out is therefore "no borrow".
        r_opA   <= inA;
        r_opB   <= inSub ? ~inB : inB;
        r_carry <= inSub ? ~inCarry : inCarry;
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        r_work  <= w_merged;
        r_carry <= w_step[CHUNK];
        r_idx   <= r_idx + 1'b1;
        if (w_last) begin
          r_idx       <= '0;
          outSum      <= w_merged;
          outCarry    <= w_step[CHUNK];
          outOverflow <= (r_opA[WIDTH-1] == r_opB[WIDTH-1]) &&
                         (w_merged[WIDTH-1] != r_opA[WIDTH-1]);
          outDone     <= 1'b1;
        end
      end
    end
  end

  assign outBusy = (r_state == S_RUN);

endmodule

// File: tb/tb_adder_multicycle.sv
// Bench for adder_multicycle: four instances (CHUNK 16/1/8/64) checked every
// cycle against an arithmetic model, plus directed literal cases on CHUNK=16.
module tb_adder_multicycle;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inStart [NI];
  logic        inSub   [NI];
  logic        inCarry [NI];
  logic [63:0] inA     [NI];
  logic [63:0] inB     [NI];
  logic        outBusy [NI];
  logic        outDone [NI];
  logic        outCarry[NI];
  logic        outOverflow[NI];
  logic [63:0] outSum  [NI];

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int chunk_of(int g);
    case (g)
      0: return 16;
      1: return 1;
      2: return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int nsteps(int g);
    return 64 / chunk_of(g);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int C = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 8 : 64;
    adder_multicycle #(.WIDTH(64), .CHUNK(C)) u_dut (
      .clk(clk), .rst(rst), .inStart(inStart[g]), .inSub(inSub[g]),
      .inA(inA[g]), .inB(inB[g]), .inCarry(inCarry[g]),
      .outBusy(outBusy[g]), .outDone(outDone[g]), .outSum(outSum[g]),
      .outCarry(outCarry[g]), .outOverflow(outOverflow[g])
    );
  end

  function automatic void chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    else n_pass++;
  endfunction

  // Reference result {ov, carry, sum} from plain integer arithmetic.
  function automatic logic [65:0] model_res(bit sub, logic [63:0] a, logic [63:0] b, bit cin);
    logic [64:0] u;
    logic [65:0] s, sa, sb;
    logic [63:0] sum;
    logic        c, ov;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    if (!sub) begin
      u   = {1'b0, a} + {1'b0, b} + 65'(cin);
      sum = u[63:0];
      c   = u[64];
      s   = sa + sb + 66'(cin);
    end else begin
      sum = a - b - 64'(cin);
      c   = ({1'b0, a} >= ({1'b0, b} + 65'(cin)));
      s   = sa - sb - 66'(cin);
    end
    ov = !((s[65] == s[64]) && (s[64] == s[63]));
    return {ov, c, sum};
  endfunction

  int          m_cnt [NI];
  logic        m_done[NI];
  logic [65:0] m_res [NI];
  logic [65:0] p_res [NI];

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        m_cnt[g]  <= 0;
        m_done[g] <= 1'b0;
        m_res[g]  <= '0;
      end else if (m_cnt[g] == 0) begin
        m_done[g] <= 1'b0;
        if (inStart[g]) begin
          p_res[g] <= model_res(inSub[g], inA[g], inB[g], inCarry[g]);
          m_cnt[g] <= nsteps(g);
        end
      end else begin
        m_cnt[g] <= m_cnt[g] - 1;
        if (m_cnt[g] == 1) begin
          m_res[g]  <= p_res[g];
          m_done[g] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++)
        chk($sformatf("cyc_g%0d{busy,done,ov,c,sum}", g),
            {outBusy[g], outDone[g], outOverflow[g], outCarry[g], outSum[g]},
            {(m_cnt[g] != 0), m_done[g], m_res[g]});
    end
  end

  // Caller is at a negedge; inputs are scrambled right after the capture edge.
  task automatic start_op(int g, bit sub, logic [63:0] a, logic [63:0] b, bit cin);
    inStart[g] = 1'b1; inSub[g] = sub; inA[g] = a; inB[g] = b; inCarry[g] = cin;
    @(negedge clk);
    inStart[g] = 1'b0;
    inSub[g]   = 1'($urandom);
    inCarry[g] = 1'($urandom);
    inA[g]     = {$urandom, $urandom};
    inB[g]     = {$urandom, $urandom};
  endtask

  task automatic wait_done(int g, output int n);
    n = 0;
    while (outDone[g] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen_g%0d", g), outDone[g], 1'b1);
  endtask

  task automatic run_op(int g, bit sub, logic [63:0] a, logic [63:0] b, bit cin);
    int n;
    start_op(g, sub, a, b, cin);
    wait_done(g, n);
    chk($sformatf("latency_g%0d", g), n, nsteps(g));
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n, seen;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      inStart[g] = 1'b0; inSub[g] = 1'b0; inCarry[g] = 1'b0; inA[g] = '0; inB[g] = '0;
    end
    inStart[0] = 1'b1;  // reset must override a start on the same edge
    repeat (3) @(negedge clk);
    inStart[0] = 1'b0;
    chk_en = 1'b1;
    chk("reset_outs", {outBusy[0], outDone[0], outCarry[0], outOverflow[0], outSum[0]}, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    chk("add_carry32_sum", outSum[0], 64'h0000_0001_0000_0000);
    chk("add_carry32_c", outCarry[0], 1'b0);
    chk("model_pin_sum", m_res[0][63:0], 64'h0000_0001_0000_0000);

    run_op(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("add_wrap", {outOverflow[0], outCarry[0], outSum[0]}, {1'b0, 1'b1, 64'h0});

    run_op(0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("add_posov", {outOverflow[0], outCarry[0], outSum[0]}, {1'b1, 1'b0, 64'h8000_0000_0000_0000});
    chk("model_pin_ov", m_res[0][65:64], 2'b10);

    run_op(0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    chk("add_negov", {outOverflow[0], outCarry[0], outSum[0]}, {1'b1, 1'b1, 64'h0});

    run_op(0, 1'b1, 64'd5, 64'd7, 1'b0);
    chk("sub_borrow", {outCarry[0], outSum[0]}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});

    run_op(0, 1'b1, 64'd7, 64'd5, 1'b1);
    chk("sub_cin", {outCarry[0], outSum[0]}, {1'b1, 64'h1});

    // start during RUN is ignored
    start_op(0, 1'b0, 64'd100, 64'd23, 1'b0);
    inStart[0] = 1'b1; inA[0] = 64'd9999; inB[0] = 64'd1; inSub[0] = 1'b1;
    @(negedge clk);
    inStart[0] = 1'b0;
    wait_done(0, n);
    chk("ignore_lat", n, 3);
    chk("ignore_sum", outSum[0], 64'd123);

    // back-to-back: new start in the outDone cycle
    run_op(0, 1'b0, 64'd1, 64'd2, 1'b1);
    chk("b2b_first", outSum[0], 64'd4);
    run_op(0, 1'b1, 64'd50, 64'd8, 1'b0);
    chk("b2b_second", outSum[0], 64'd42);

    // reset in the 2nd RUN cycle aborts
    start_op(0, 1'b0, 64'd10, 64'd20, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outs", {outBusy[0], outDone[0], outCarry[0], outOverflow[0], outSum[0]}, '0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (outDone[0] === 1'b1) seen++;
    end
    chk("abort_nodone", seen, 0);

    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_op(g, 1'($urandom), pick(), pick(), 1'($urandom));
      end
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
